ccff_bitstream_loader: RTL

- Transmitter side of the configuration-chain (ccff) protocol.
- Accepts bitstream bytes from the host/pin interface over a valid/ready handshake and serializes them onto ccff_head.
- Each transferred bit is qualified by a one-cycle ccff_shift_en, which gates the fabric's configuration flops.
- Captures ccff_tail as readback and flags completion once exactly CHAIN_LEN bits have been shifted. Sits between the top-level I/O wrapper and the fabric's ccff chain.

---
 rtl/ccff_bitstream_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serializes host bytes MSB-first onto the configuration chain head and captures the tail as readback.
// Each word costs 1 accept cycle plus one cycle per shifted bit; all outputs are registered.
// data_ready is held only in LOAD; the host may stall indefinitely there without any shift pulses.
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned BYTE_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              readback_bit,
    output logic              readback_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned NB_W = $clog2(BYTE_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] sreg_q, sreg_d;
    logic [NB_W-1:0]   nbits_q, nbits_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              rb_bit_q, rb_bit_d;
    logic              rb_vld_q, rb_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  remaining;

    assign remaining = CNT_W'(CHAIN_LEN) - cnt_q;

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        nbits_d    = nbits_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        shift_en_d = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        ready_d    = ready_q;
        // The tail is sampled on the same edge the chain shifts, so it is the old tail bit.
        rb_vld_d   = shift_en_q;
        rb_bit_d   = shift_en_q ? ccff_tail : rb_bit_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end else if (data_valid && ready_q) begin
                    state_d = SHIFT;
                    sreg_d  = data_in;
                    ready_d = 1'b0;
                    nbits_d = (remaining < CNT_W'(BYTE_W)) ? NB_W'(remaining) : NB_W'(BYTE_W);
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end else begin
                    head_d     = sreg_q[BYTE_W-1];
                    shift_en_d = 1'b1;
                    sreg_d     = sreg_q << 1;
                    nbits_d    = nbits_q - NB_W'(1);
                    if (cnt_q != CNT_W'(CHAIN_LEN)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (nbits_q == NB_W'(1)) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(CHAIN_LEN)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = LOAD;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            nbits_q    <= '0;
            cnt_q      <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            rb_bit_q   <= 1'b0;
            rb_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            nbits_q    <= nbits_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            rb_bit_q   <= rb_bit_d;
            rb_vld_q   <= rb_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign data_ready     = ready_q;
    assign ccff_head      = head_q;
    assign ccff_shift_en  = shift_en_q;
    assign readback_bit   = rb_bit_q;
    assign readback_valid = rb_vld_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bit_count      = cnt_q;

endmodule
